// File: rtl/aud_pkg.sv
// Shared types and default widths for the audio player core.
package aud_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSED,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_CALC,
    ST_OUT
  } state_e;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_FAST   = 2'd1,
    MODE_HOLD   = 2'd2,
    MODE_LINEAR = 2'd3
  } mode_e;

endpackage

// File: rtl/aud_interp.sv
// Combinational sample generator: mode select, linear interpolation between
// prev and cur, and the final arithmetic gain shift.
module aud_interp
  import aud_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SPD_W  = 3,
  parameter int GAIN_W = 3
) (
  input  logic [1:0]        mode,
  input  logic [SPD_W-1:0]  speed,
  input  logic [SPD_W-1:0]  k,
  input  logic [GAIN_W-1:0] gain,
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] sample
);

  localparam int PW = DATA_W + SPD_W + 2;
  localparam logic signed [PW-1:0] ONE = PW'(1);

  logic signed [PW-1:0]     prev_ext;
  logic signed [PW-1:0]     cur_ext;
  logic signed [PW-1:0]     diff;
  logic signed [PW-1:0]     kp1;
  logic signed [PW-1:0]     n_fac;
  logic signed [PW-1:0]     num;
  logic signed [PW-1:0]     quot;
  logic signed [DATA_W-1:0] lin;
  logic signed [DATA_W-1:0] sel;

  always_comb begin
    prev_ext = PW'($signed(prev));
    cur_ext  = PW'($signed(cur));
    diff     = cur_ext - prev_ext;
    kp1      = $signed(PW'(k)) + ONE;
    n_fac    = $signed(PW'(speed)) + ONE;
    num      = diff * kp1;
    // Signed division truncates toward zero; the sum always lies between prev and cur.
    quot     = num / n_fac;
    lin      = DATA_W'(prev_ext + quot);
    unique case (mode)
      MODE_NORMAL, MODE_FAST: sel = $signed(cur);
      MODE_HOLD:              sel = (k < speed) ? $signed(prev) : $signed(cur);
      MODE_LINEAR:            sel = lin;
      default:                sel = $signed(cur);
    endcase
    sample = sel >>> gain;
  end

endmodule

// File: rtl/aud_player_core.sv
// LRCK-paced SRAM sample player: one sample per LRCK period with normal,
// skip, hold and linear-interpolated speed modes, reverse and loop playback.
module aud_player_core
  import aud_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SPD_W  = 3,
  parameter int GAIN_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic              i_reverse,
  input  logic              i_loop,
  input  logic [GAIN_W-1:0] i_gain,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_dac_valid,
  output logic              o_finish,
  output logic              o_busy
);

  localparam int AW1 = ADDR_W + 1;

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] start_reg, start_next;
  logic [ADDR_W-1:0] end_reg, end_next;
  logic [DATA_W-1:0] dac_reg, dac_next;
  logic [DATA_W-1:0] prev_reg, prev_next;
  logic [SPD_W-1:0]  k_reg, k_next;
  logic [SPD_W-1:0]  speed_reg, speed_next;
  logic [1:0]        mode_reg, mode_next;
  logic              rev_reg, rev_next;
  logic              loop_reg, loop_next;
  logic              fin_reg, fin_next;
  logic              rej_reg, rej_next;

  logic [DATA_W-1:0] sample;
  logic              advance;
  logic              hit_end;
  logic [AW1-1:0]    step;
  logic [AW1-1:0]    fwd_addr;
  logic [ADDR_W-1:0] rev_addr;

  aud_interp #(
    .DATA_W(DATA_W),
    .SPD_W (SPD_W),
    .GAIN_W(GAIN_W)
  ) u_interp (
    .mode  (mode_reg),
    .speed (speed_reg),
    .k     (k_reg),
    .gain  (i_gain),
    .prev  (prev_reg),
    .cur   (i_sram_data),
    .sample(sample)
  );

  // Region-end detection is done one bit wider so the address never wraps.
  always_comb begin
    advance  = (mode_reg == MODE_NORMAL) || (mode_reg == MODE_FAST) || (k_reg == speed_reg);
    step     = (mode_reg == MODE_FAST) ? AW1'(speed_reg) + AW1'(1) : AW1'(1);
    fwd_addr = AW1'(addr_reg) + step;
    rev_addr = addr_reg - step[ADDR_W-1:0];
    if (rev_reg) hit_end = advance && (AW1'(addr_reg) < AW1'(start_reg) + step);
    else         hit_end = advance && (fwd_addr > AW1'(end_reg));
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    start_next = start_reg;
    end_next   = end_reg;
    dac_next   = dac_reg;
    prev_next  = prev_reg;
    k_next     = k_reg;
    speed_next = speed_reg;
    mode_next  = mode_reg;
    rev_next   = rev_reg;
    loop_next  = loop_reg;
    fin_next   = fin_reg;
    rej_next   = 1'b0;
    if (i_stop) begin
      state_next = ST_IDLE;
      addr_next  = start_reg;
      k_next     = '0;
      prev_next  = '0;
      fin_next   = 1'b0;
    end else if (i_pause && state_reg != ST_IDLE) begin
      state_next = ST_PAUSED;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            if (i_start_addr <= i_end_addr) begin
              mode_next  = i_mode;
              speed_next = i_speed;
              rev_next   = i_reverse;
              loop_next  = i_loop;
              start_next = i_start_addr;
              end_next   = i_end_addr;
              addr_next  = i_reverse ? i_end_addr : i_start_addr;
              k_next     = '0;
              prev_next  = '0;
              fin_next   = 1'b0;
              state_next = ST_WAIT_LO;
            end else begin
              rej_next = 1'b1;
            end
          end
        end
        ST_PAUSED:  if (i_start)    state_next = ST_WAIT_LO;
        ST_WAIT_LO: if (!i_daclrck) state_next = ST_WAIT_HI;
        ST_WAIT_HI: if (i_daclrck)  state_next = ST_CALC;
        ST_CALC: begin
          dac_next   = sample;
          fin_next   = hit_end && !loop_reg;
          state_next = ST_OUT;
          if (advance) begin
            k_next    = '0;
            prev_next = i_sram_data;
            if (!hit_end)      addr_next = rev_reg ? rev_addr : fwd_addr[ADDR_W-1:0];
            else if (loop_reg) addr_next = rev_reg ? end_reg : start_reg;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
        ST_OUT:  state_next = fin_reg ? ST_IDLE : ST_WAIT_LO;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      start_reg <= '0;
      end_reg   <= '0;
      dac_reg   <= '0;
      prev_reg  <= '0;
      k_reg     <= '0;
      speed_reg <= '0;
      mode_reg  <= '0;
      rev_reg   <= 1'b0;
      loop_reg  <= 1'b0;
      fin_reg   <= 1'b0;
      rej_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      start_reg <= start_next;
      end_reg   <= end_next;
      dac_reg   <= dac_next;
      prev_reg  <= prev_next;
      k_reg     <= k_next;
      speed_reg <= speed_next;
      mode_reg  <= mode_next;
      rev_reg   <= rev_next;
      loop_reg  <= loop_next;
      fin_reg   <= fin_next;
      rej_reg   <= rej_next;
    end
  end

  assign o_sram_addr = addr_reg;
  assign o_dac_data  = dac_reg;
  assign o_dac_valid = (state_reg == ST_OUT);
  assign o_finish    = rej_reg || ((state_reg == ST_OUT) && fin_reg);
  assign o_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_aud_player_core.sv
// Directed self-checking bench for aud_player_core with a one-cycle-latency SRAM model.
module tb_aud_player_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, pause, stop;
  logic [1:0]  mode;
  logic [2:0]  speed;
  logic        reverse, loop;
  logic [2:0]  gain;
  logic [19:0] start_addr, end_addr;
  logic        daclrck;
  logic [15:0] sram_data;
  logic [19:0] sram_addr;
  logic [15:0] dac_data;
  logic        dac_valid, finish, busy;

  logic [15:0] mem [64];

  int tests = 0;
  int fails = 0;
  int got_q[$];
  int fin_q[$];
  int addr_q[$];
  int fin_cnt = 0;
  int base = 0;
  int fb = 0;
  int held = 0;

  aud_player_core dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_mode      (mode),
    .i_speed     (speed),
    .i_reverse   (reverse),
    .i_loop      (loop),
    .i_gain      (gain),
    .i_start_addr(start_addr),
    .i_end_addr  (end_addr),
    .i_daclrck   (daclrck),
    .i_sram_data (sram_data),
    .o_sram_addr (sram_addr),
    .o_dac_data  (dac_data),
    .o_dac_valid (dac_valid),
    .o_finish    (finish),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_data <= mem[sram_addr[5:0]];

  // LRCK period of 16 clocks
  initial begin
    daclrck = 1'b0;
    forever begin
      repeat (8) @(negedge clk);
      daclrck = ~daclrck;
    end
  end

  always @(negedge clk) begin
    if (rst_n && dac_valid) begin
      got_q.push_back(int'($signed(dac_data)));
      fin_q.push_back(int'(finish));
      addr_q.push_back(int'(sram_addr));
      $display("[TB] strobe data=%0d addr=%0d finish=%0b", $signed(dac_data), sram_addr, finish);
    end
    if (rst_n && finish) fin_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    tick(1);
  endtask

  task automatic mark();
    base = got_q.size();
    fb   = fin_cnt;
  endtask

  task automatic wait_strobes(input string tag, input int n);
    for (int i = 0; i < 400 && got_q.size() < base + n; i++) @(negedge clk);
    chk(tag, int'(got_q.size() >= base + n), 1);
  endtask

  task automatic set_cfg(input int m, input int s, input int r, input int l,
                         input int sa, input int ea, input int g);
    mode       = 2'(m);
    speed      = 3'(s);
    reverse    = 1'(r);
    loop       = 1'(l);
    start_addr = 20'(sa);
    end_addr   = 20'(ea);
    gain       = 3'(g);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) mem[i] = 16'((i + 1) * 10);
    tick(3);
    chk("rst_addr",   int'(sram_addr), 0);
    chk("rst_dac",    int'(dac_data), 0);
    chk("rst_valid",  int'(dac_valid), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_busy",   int'(busy), 0);
    rst_n = 1'b1;
    tick(2);

    // Normal mode, region 0..3, finishes on the 4th sample
    set_cfg(0, 0, 0, 0, 0, 3, 0);
    mark(); pulse_start();
    wait_strobes("m0_count", 4);
    chk("m0_s0", got_q[base + 0], 10);
    chk("m0_s1", got_q[base + 1], 20);
    chk("m0_s2", got_q[base + 2], 30);
    chk("m0_s3", got_q[base + 3], 40);
    chk("m0_fin_early", fin_q[base + 2], 0);
    chk("m0_fin_last", fin_q[base + 3], 1);
    tick(3);
    chk("m0_idle", int'(busy), 0);
    chk("m0_fin_cnt", fin_cnt - fb, 1);

    // Linear interpolation N=4 from prev=0 to cur=100
    set_cfg(3, 3, 0, 0, 9, 20, 0);
    mark(); pulse_start();
    wait_strobes("m3_count", 4);
    chk("m3_s0", got_q[base + 0], 25);
    chk("m3_s1", got_q[base + 1], 50);
    chk("m3_s2", got_q[base + 2], 75);
    chk("m3_s3", got_q[base + 3], 100);
    chk("m3_addr_hold", addr_q[base + 2], 9);
    chk("m3_addr_step", addr_q[base + 3], 10);
    // stop and pause together: stop wins
    @(negedge clk) begin stop = 1'b1; pause = 1'b1; end
    @(negedge clk) begin stop = 1'b0; pause = 1'b0; end
    tick(1);
    chk("stop_pause_busy", int'(busy), 0);
    chk("stop_pause_addr", int'(sram_addr), 9);

    // Same with gain shift of 1
    set_cfg(3, 3, 0, 0, 9, 20, 1);
    mark(); pulse_start();
    wait_strobes("gain_count", 4);
    chk("gain_s0", got_q[base + 0], 12);
    chk("gain_s1", got_q[base + 1], 25);
    chk("gain_s2", got_q[base + 2], 37);
    chk("gain_s3", got_q[base + 3], 50);
    pulse_stop();

    // Fast reverse N=3, region 2..9: addresses 9,6,3
    set_cfg(1, 2, 1, 0, 2, 9, 0);
    mark(); pulse_start();
    wait_strobes("rev_count", 3);
    chk("rev_s0", got_q[base + 0], 100);
    chk("rev_s1", got_q[base + 1], 70);
    chk("rev_s2", got_q[base + 2], 40);
    chk("rev_fin_early", fin_q[base + 1], 0);
    chk("rev_fin_last", fin_q[base + 2], 1);
    tick(3);
    chk("rev_idle", int'(busy), 0);

    // Same with loop: wraps back to 9, no finish
    set_cfg(1, 2, 1, 1, 2, 9, 0);
    mark(); pulse_start();
    wait_strobes("loop_count", 4);
    chk("loop_s2", got_q[base + 2], 40);
    chk("loop_s3", got_q[base + 3], 100);
    chk("loop_no_fin", fin_cnt - fb, 0);
    pulse_stop();
    chk("loop_stop_addr", int'(sram_addr), 2);

    // Pause after 2nd strobe for 5 LRCK periods, then resume
    set_cfg(0, 0, 0, 0, 0, 9, 0);
    mark(); pulse_start();
    wait_strobes("pause_pre", 2);
    @(negedge clk) pause = 1'b1;
    @(negedge clk) pause = 1'b0;
    held = got_q.size();
    tick(80);
    chk("pause_no_strobe", got_q.size() - held, 0);
    chk("pause_busy", int'(busy), 1);
    chk("pause_dac_hold", int'(dac_data), 20);
    pulse_start();
    wait_strobes("pause_post", 3);
    chk("pause_s2", got_q[base + 2], 30);
    pulse_stop();

    // Rejected start: start > end
    set_cfg(0, 0, 0, 0, 8, 4, 0);
    mark();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("rej_finish", int'(finish), 1);
    chk("rej_busy", int'(busy), 0);
    tick(1);
    chk("rej_finish_end", int'(finish), 0);
    chk("rej_busy_after", int'(busy), 0);
    chk("rej_fin_cnt", fin_cnt - fb, 1);

    // Reset mid-run
    set_cfg(0, 0, 0, 0, 0, 9, 0);
    mark(); pulse_start();
    wait_strobes("rstrun_pre", 1);
    tick(5);
    fb = fin_cnt;
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rstrun_addr",   int'(sram_addr), 0);
    chk("rstrun_dac",    int'(dac_data), 0);
    chk("rstrun_valid",  int'(dac_valid), 0);
    chk("rstrun_finish", int'(finish), 0);
    chk("rstrun_busy",   int'(busy), 0);
    tick(3);
    chk("rstrun_no_fin", fin_cnt - fb, 0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
